// File: rtl/carregador_programa.sv
// Program loader: streams 32-bit instruction words into instruction memory,
// holding the core stalled until the image is complete.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, n_words   load request (IDLE only) and requested word count
//   in_valid/in_data upstream instruction stream; in_ready = accept
//   mi_we/addr/data  registered instruction-memory write port
//   core_hold        stall for control unit / datapath
//   busy, done       load in progress / one-cycle completion pulse
//   count, checksum  words accepted and their 32-bit sum since last start
module carregador_programa #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_words,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  mi_we,
    output logic [63:0]           mi_addr,
    output logic [31:0]           mi_data,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic [31:0]           checksum
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   n_lim_q, n_lim_d;
    logic            in_ready_q, in_ready_d;
    logic            mi_we_q, mi_we_d;
    logic [63:0]     mi_addr_q, mi_addr_d;
    logic [31:0]     mi_data_q, mi_data_d;
    logic            core_hold_q, core_hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     checksum_q, checksum_d;

    logic            xfer_c;
    logic [CW-1:0]   lim_c;

    // in_ready_q is only ever high in LOAD, so it alone qualifies a transfer
    assign xfer_c = in_valid & in_ready_q;
    // Clamp the request to the memory depth so addresses can never wrap
    assign lim_c  = (n_words > DEPTH) ? DEPTH : n_words;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_lim_q     <= '0;
            in_ready_q  <= 1'b0;
            mi_we_q     <= 1'b0;
            mi_addr_q   <= BASE_ADDR;
            mi_data_q   <= '0;
            core_hold_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_lim_q     <= n_lim_d;
            in_ready_q  <= in_ready_d;
            mi_we_q     <= mi_we_d;
            mi_addr_q   <= mi_addr_d;
            mi_data_q   <= mi_data_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            checksum_q  <= checksum_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        n_lim_d     = n_lim_q;
        in_ready_d  = in_ready_q;
        mi_we_d     = 1'b0;
        mi_addr_d   = mi_addr_q;
        mi_data_d   = mi_data_q;
        core_hold_d = core_hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        count_d     = count_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                if (start) begin
                    n_lim_d     = lim_c;
                    count_d     = '0;
                    checksum_d  = '0;
                    core_hold_d = 1'b1;
                    busy_d      = 1'b1;
                    if (lim_c == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xfer_c) begin
                    mi_we_d    = 1'b1;
                    mi_addr_d  = BASE_ADDR + 64'({count_q, 2'b00});
                    mi_data_d  = in_data;
                    count_d    = count_q + CW'(1);
                    checksum_d = checksum_q + in_data;
                    if (count_d == n_lim_q) begin
                        state_d    = S_DRAIN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Last write is on the port this cycle; release the core next
                state_d     = S_IDLE;
                in_ready_d  = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                core_hold_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign mi_we     = mi_we_q;
    assign mi_addr   = mi_addr_q;
    assign mi_data   = mi_data_q;
    assign core_hold = core_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign checksum  = checksum_q;

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader sitting directly upstream of the RISC-V datapath's instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them sequentially into instruction memory. It holds the control unit/datapath pair in a stalled state until a load completes. It also reports the word count and a running checksum so benches can confirm the image before the core runs.

## Interface
Parameters:
- ADDR_WIDTH, 8: instruction-memory depth in words is 2^ADDR_WIDTH.
- BASE_ADDR, 64'h0: byte address of the first word written.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- n_words  in  ADDR_WIDTH+1  words to load; sampled with start.
- in_valid  in  1  upstream word available.
- in_data  in  32  instruction word.
- in_ready  out  1  loader accepts in_data this cycle.
- mi_we  out  1  instruction-memory write enable (drives we_mi path).
- mi_addr  out  64  byte address of the write.
- mi_data  out  32  word to write.
- core_hold  out  1  high = uc/datapath must not advance PC or write state.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse when a load completes.
- count  out  ADDR_WIDTH+1  words accepted since the last start.
- checksum  out  32  sum of accepted words, mod 2^32.

## Operation
- Three states: IDLE, LOAD, DRAIN.
- IDLE:
  - in_ready=0, busy=0.
  - On start: latch n_lim = min(n_words, 2^ADDR_WIDTH), clear count and checksum, assert core_hold.
  - If n_lim==0, go to DRAIN; otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready.
  - On each transfer, register the write: mi_data=in_data, mi_addr=BASE_ADDR+4*count, count+=1, checksum+=in_data (32-bit wrap).
  - When the transfer brings count to n_lim, go to DRAIN.
  - in_valid low simply stalls; there is no timeout.
- DRAIN:
  - in_ready=0.
  - The final registered write (if any) is presented this cycle.
  - Next edge: state=IDLE, done=1 for exactly one cycle, core_hold=0 from that same cycle.
- mi_we is high only in the cycle after a transfer; mi_addr/mi_data hold their last values otherwise.
- start while busy is ignored. start in IDLE after a completed load begins a fresh load and re-asserts core_hold.
- Addresses never wrap: n_lim is clamped to the memory depth, so the maximum address is BASE_ADDR+4*(2^ADDR_WIDTH-1).
- Transfers beyond n_lim are impossible because in_ready is low outside LOAD.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, mi_we=0, mi_addr=BASE_ADDR, mi_data=0
  - busy=0, done=0, count=0, checksum=0
  - core_hold=1: the core stays stalled after reset until the first load completes.
- Reset during LOAD/DRAIN:
  - Returns to the reset values on the next edge.
  - A pending registered write is dropped (mi_we=0).
- Latency:
  - Transfer in cycle k gives mi_we in cycle k+1. Throughput is 1 word/cycle.
  - Last transfer at cycle k gives DRAIN at k+1 (last write), then done and core_hold=0 at k+2.
  - A zero-length load: start at cycle k, DRAIN at k+1, done at k+2, with no mi_we.
- count and checksum update on the same edge that raises mi_we for that word.

## Test plan
- Reset, then idle 5 cycles:
  - core_hold=1; in_ready, mi_we, done, busy = 0; count=0.
- start with n_words=3; stream 0x00400313, 0x00A00093, 0x00000013 with in_valid held high:
  - mi_we in 3 consecutive cycles at addresses 0x0, 0x4, 0x8.
  - done 2 cycles after the last transfer; count=3; checksum=0x00E003B9; core_hold=0.
- Same load with in_valid toggling 1,0,1,0,1:
  - Writes occur only after valid cycles.
  - Identical addresses, data, count and checksum.
- start with n_words=0:
  - No mi_we; done at the second edge after start; core_hold drops with done.
- Assert reset in the cycle after the second transfer of a 4-word load:
  - No further mi_we; all outputs return to reset values; a new start loads correctly from address BASE_ADDR.
- ADDR_WIDTH=2, n_words=7:
  - Exactly 4 writes (0x0–0xC); in_ready falls after the 4th transfer; count=4.
- start pulsed during LOAD:
  - Ignored; count and addresses continue uninterrupted.
